// File: rtl/tl_rr_arbiter_sm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tl_rr_arbiter_sm
// Purpose  : Transaction-layer sequencer (RESET/INIT/IDLE/ACTIVE) and
//            round-robin drain of four input FIFOs into one output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tl_rr_arbiter_sm #(
    parameter int DATA_W = 10,
    parameter int N_IN   = 4
) (
    input  logic                   clk,
    input  logic                   reset_L,
    input  logic                   init,
    input  logic [2:0]             umbral_superior_in,
    input  logic [2:0]             umbral_inferior_in,
    output logic [3:0]             state,
    output logic [2:0]             umbral_superior,
    output logic [2:0]             umbral_inferior,
    input  logic [N_IN-1:0]        in_empty,
    input  logic [N_IN*DATA_W-1:0] in_data,
    output logic [N_IN-1:0]        in_pop,
    input  logic                   out_almost_full,
    output logic                   out_push,
    output logic [DATA_W-1:0]      out_data,
    output logic                   idle,
    output logic [7:0]             push_count
);

    localparam int PTR_W = 2;

    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [N_IN-1:0]     in_pop_q, in_pop_d;
    logic [N_IN-1:0]     sel_q, sel_d;
    logic                out_push_q, out_push_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [7:0]          push_count_q, push_count_d;
    logic [2:0]          usup_q, usup_d;
    logic [2:0]          uinf_q, uinf_d;

    logic                pipe_empty;
    logic                can_pop;
    logic [N_IN-1:0]     elig;
    logic [DATA_W-1:0]   cap_word;
    logic [PTR_W-1:0]    idx;
    logic                found;

    // A FIFO popped last cycle is skipped so its empty flag can settle.
    assign pipe_empty = (in_pop_q == '0) && (sel_q == '0);
    assign can_pop    = (state_q == ST_ACTIVE) && !out_almost_full && !init;
    assign elig       = can_pop ? (~in_empty & ~in_pop_q) : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   if (!init) state_d = ST_IDLE;
            ST_IDLE: begin
                if (init)               state_d = ST_INIT;
                else if (!(&in_empty))  state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (pipe_empty) begin
                    if (init)           state_d = ST_INIT;
                    else if (&in_empty) state_d = ST_IDLE;
                end
            end
            default:   state_d = ST_RESET;
        endcase
    end

    always_comb begin
        in_pop_d = '0;
        ptr_d    = ptr_q;
        found    = 1'b0;
        idx      = ptr_q;
        for (int k = 1; k <= N_IN; k++) begin
            idx = PTR_W'(ptr_q + PTR_W'(k));
            if (!found && elig[idx]) begin
                found         = 1'b1;
                in_pop_d[idx] = 1'b1;
                ptr_d         = idx;
            end
        end
        if (state_q == ST_INIT) begin
            ptr_d = PTR_W'(N_IN - 1);
        end
    end

    always_comb begin
        cap_word = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (sel_q[i]) cap_word = in_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        sel_d        = in_pop_q;
        out_push_d   = |sel_q;
        out_data_d   = (|sel_q) ? cap_word : out_data_q;
        push_count_d = (|sel_q) ? push_count_q + 8'd1 : push_count_q;
        usup_d       = usup_q;
        uinf_d       = uinf_q;
        if (state_q == ST_INIT) begin
            push_count_d = '0;
            usup_d       = umbral_superior_in;
            uinf_d       = umbral_inferior_in;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= ST_RESET;
            ptr_q        <= PTR_W'(N_IN - 1);
            in_pop_q     <= '0;
            sel_q        <= '0;
            out_push_q   <= 1'b0;
            out_data_q   <= '0;
            push_count_q <= '0;
            usup_q       <= '0;
            uinf_q       <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            in_pop_q     <= in_pop_d;
            sel_q        <= sel_d;
            out_push_q   <= out_push_d;
            out_data_q   <= out_data_d;
            push_count_q <= push_count_d;
            usup_q       <= usup_d;
            uinf_q       <= uinf_d;
        end
    end

    assign state           = state_q;
    assign idle            = (state_q == ST_IDLE);
    assign in_pop          = in_pop_q;
    assign out_push        = out_push_q;
    assign out_data        = out_data_q;
    assign push_count      = push_count_q;
    assign umbral_superior = usup_q;
    assign umbral_inferior = uinf_q;

endmodule
`default_nettype wire

// File: doc/tl_rr_arbiter_sm.md
# tl_rr_arbiter_sm

Main sequencer and round-robin arbiter for the transaction-layer FIFO datapath. It generates the 4-bit `state` bus (RESET/INIT/IDLE/ACTIVE) that all FIFOs consume, and latches and distributes the almost-full/almost-empty thresholds during INIT. In ACTIVE it drains four input FIFOs into one output FIFO, popping them round-robin and pushing the popped words downstream with a fixed 2-cycle latency. Pops are throttled by the downstream `almost_full`.

## Interface
- `DATA_W`, 10: word width of every FIFO.
- `N_IN`, 4: number of input FIFOs (fixed at 4; the port widths below assume 4).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_L` in 1: asynchronous, active-low reset.
- `init` in 1: request to enter or stay in INIT.
- `umbral_superior_in` in 3: almost-full threshold to latch.
- `umbral_inferior_in` in 3: almost-empty threshold to latch.
- `state` out 4: one-hot state bus. RESET=0001, INIT=0010, IDLE=0100, ACTIVE=1000.
- `umbral_superior`, `umbral_inferior` out 3: latched thresholds, driven to every FIFO.
- `in_empty` in 4: `empty` flags of input FIFOs 0..3.
- `in_data` in 4*DATA_W: `data_out` of input FIFO i, on bits [i*DATA_W +: DATA_W].
- `in_pop` out 4: registered pop, one-hot or zero.
- `out_almost_full` in 1: `almost_full` of the output FIFO.
- `out_push` out 1: registered push to the output FIFO.
- `out_data` out DATA_W: registered write data.
- `idle` out 1: high when `state`==IDLE.
- `push_count` out 8: number of `out_push` pulses since the last INIT.

## Operation
- `reset_L` low clears everything immediately:
  - `state`=0001; `in_pop`=0; `out_push`=0; `out_data`=0; `idle`=0; `push_count`=0.
  - thresholds=0; round-robin pointer=3, so FIFO 0 has priority first.
- State transitions:
  - RESET → INIT on the first edge after `reset_L` rises.
  - INIT: at every edge, latch `umbral_*_in` into `umbral_*`, clear `push_count`, reset the RR pointer to 3. Leave to IDLE at the first edge where `init`=0.
  - IDLE: `init`=1 → INIT (highest priority). Otherwise, any `in_empty` bit 0 → ACTIVE.
  - ACTIVE → INIT when `init`=1 and the pipeline is empty, meaning no pop in flight and no pending push.
  - ACTIVE → IDLE when all `in_empty`=1 and the pipeline is empty.
- Pop issue in ACTIVE, at each edge:
  - Precondition: `out_almost_full`=0 and `init`=0.
  - FIFO i is eligible when `in_empty[i]`=0 and i was not popped in the previous cycle (the gap lets `empty` update).
  - Grant the first eligible i, searching upward from pointer+1 modulo 4. Set `in_pop[i]`=1 and pointer=i.
  - No eligible FIFO → `in_pop`=0 and the pointer is unchanged.
- While `init`=1 in ACTIVE: no new pops; in-flight words still complete.
- `in_pop` and `out_push` are only ever asserted in ACTIVE, plus the pipeline-drain cycles before an exit transition.
- `push_count` increments by 1 on each `out_push`. It wraps 255 → 0 and is cleared in INIT.

## Timing
- Pop-to-push latency: 2 cycles.
  - `in_pop[i]` high in cycle N.
  - FIFO i `data_out` is valid in cycle N+1; the arbiter captures it.
  - `out_push`=1 and `out_data` = that word in cycle N+2.
- Throughput:
  - One pop and one push per cycle overall.
  - At most one pop per input FIFO every 2 cycles.
- Up to 2 words can be in flight when `out_almost_full` rises. The output FIFO's `umbral_superior` must therefore be ≤ 5 to avoid overflow; software responsibility.
- `out_almost_full` is sampled at the same edge that would issue a pop. A pop issued in cycle N is never cancelled.
- State changes take effect on the edge after their condition holds. `idle` tracks `state` in the same cycle.
- Asynchronous reset mid-transfer drops in-flight words. There is no recovery; upstream must re-fill.
- Simultaneous `init`=1 and non-empty inputs in IDLE: INIT wins.

## Test plan
- Reset/INIT: pulse `reset_L` low, release with `init`=1 for 3 cycles and `umbral_*_in`=6/1.
  - `state` sequence 0001 → 0010 ×3 → 0100.
  - `umbral_superior`=6, `umbral_inferior`=1; all outputs 0 during reset.
- Single-FIFO drain: FIFO 2 holds 0x011, 0x022, 0x033; others empty.
  - Pops on FIFO 2 every other cycle.
  - `out_data` = 0x011, 0x022, 0x033, each 2 cycles after its pop.
  - `push_count`=3, then return to IDLE.
- Round-robin fairness: all four FIFOs hold 2 words each.
  - Grant order 0,1,2,3,0,1,2,3 on consecutive cycles.
  - 8 pushes, `push_count`=8.
- Backpressure: hold `out_almost_full`=1 from cycle 4 to cycle 10 during the fairness test.
  - No `in_pop` in cycles 4–10.
  - At most 2 trailing pushes after the rise.
  - The grant order resumes from the next FIFO after the last granted one.
- INIT during ACTIVE: assert `init` while 2 words are in flight.
  - Both words are still pushed.
  - `state` becomes 0010 only after the pipeline is empty.
  - `push_count` is then cleared to 0.
- Counter wrap / async reset: push 257 words.
  - `push_count`=1 after the wrap.
  - Assert `reset_L`=0 mid-pop: `in_pop`, `out_push` and `state`=0001 change immediately, without waiting for a clock edge.
